doppler_iq_mixer: RTL and testbench
===================================

# doppler_iq_mixer

Parametrised successor to the current Q/I arbiter on the DRFM Doppler path. It accepts the ADC's interleaved offset-binary Q/I sample stream with an explicit valid/start-of-frame handshake and pairs the samples. It then mixes each pair against externally supplied NCO cos/sin words and emits the real shifted sample `I*cos − Q*sin` with a registered valid strobe. It sits between the ADC capture logic and the DAC/replay path, and replaces the fixed 16-bit, free-running pairing with a resynchronisable, width-generic pipeline.

## Interface
- `DATA_W`, 16: input sample width (offset binary).
- `TRIG_W`, 17: width of `cos_in`/`sin_in` (two's complement).
- `OUT_W`, 32: output width; must be ≤ `DATA_W+TRIG_W+1`.
- `Q_FIRST`, 1: 1 = the first sample of each pair is Q; 0 = the first sample is I.

- `M100CLK`  in  1  sole clock, rising-edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_data` is a valid sample this cycle.
- `in_data`  in  `DATA_W`  ADC sample, offset binary.
- `in_sof`  in  1  qualified by `in_valid`; marks the current sample as the first of a pair.
- `cos_in`  in  `TRIG_W`  NCO cosine, signed.
- `sin_in`  in  `TRIG_W`  NCO sine, signed.
- `out_valid`  out  1  one-cycle strobe per completed pair.
- `out_data`  out  `OUT_W`  mixed sample; format depends on Configuration.
- `pair_err`  out  1  one-cycle pulse when a half-pair is discarded by a resync.

## Operation
- Pairing FSM has two states: `WAIT_FIRST` and `WAIT_SECOND`. It advances only on cycles with `in_valid`=1. Cycles with `in_valid`=0 hold all state.
- `WAIT_FIRST` + valid: capture the sample as the first half and go to `WAIT_SECOND`. `in_sof` is a don't-care here.
- `WAIT_SECOND` + valid + `in_sof`=0: capture the second half, issue an internal pair strobe, and go to `WAIT_FIRST`. Sample `cos_in`/`sin_in` on this same cycle.
- `WAIT_SECOND` + valid + `in_sof`=1: discard the held first half, pulse `pair_err`, capture the current sample as the new first half, and stay in `WAIT_SECOND`.
- First/second halves map to Q/I according to `Q_FIRST`.
- Conversion: invert the MSB of each sample to get signed `DATA_W`.
- Products: `pi = I*cos`, `pq = Q*sin`, each signed `DATA_W+TRIG_W` bits, full precision.
- Difference: `d = pi − pq`, signed `DATA_W+TRIG_W+1` bits, no overflow possible.
- Output scaling: arithmetic right shift of `d` by `DATA_W+TRIG_W+1−OUT_W` (floor, no rounding). With the defaults this is a shift of 2.
- Default output format is offset binary: invert the MSB of the scaled result.

## Timing
- Let cycle T be the clock edge on which the second half is accepted.
  - T+1: converted I/Q and captured cos/sin are registered.
  - T+2: products are registered.
  - T+3: `out_data` and `out_valid`=1.
- Fixed latency is 3 cycles. The block accepts one pair per 2 valid cycles at full rate and has no backpressure.
- `pair_err` is registered and asserts on T+1 of the resyncing sample.
- `out_data` holds its value between strobes.
- Reset (`reset_n`=0 sampled on an edge):
  - FSM goes to `WAIT_FIRST`.
  - All pipeline valid bits clear.
  - `out_valid`=0, `pair_err`=0, `out_data`=0.
- Pairs in flight when reset is sampled are dropped; no `out_valid` is produced for them.
- Reset takes priority over `in_valid` on the same edge.
- The first valid sample after reset release is the first half of a pair.

## Configuration
- `DOPPLER_MIXER_TWOS_OUT_EN`:
  - Defined: `out_data` is the scaled result in two's complement (MSB not inverted).
  - Undefined: `out_data` is offset binary, matching the DAC interface.
- Latency and `out_data`'s reset value of 0 are unchanged in both builds.

## Test plan
- Defaults, offset output. Q=0x8000, I=0xC000, cos=32768, sin=0 → at T+3, `out_valid`=1 for one cycle and `out_data`=0x8800_0000.
- Defaults. Q=0xC000, I=0x8000, cos=0, sin=32768 → `out_data`=0x7800_0000.
- Resync. Send valid Q=0x1234, then valid+`in_sof` with 0x8000, then I=0xC000 (cos=32768, sin=0) → `pair_err` pulses once and the result is 0x8800_0000. No output is produced for 0x1234.
- Gaps. Insert 5 `in_valid`=0 cycles between Q and I → a single `out_valid`, 3 cycles after the I sample, with the same value as the first test.
- Reset mid-flight. Drop `reset_n` for 1 cycle at T+1 → `out_valid` never asserts for that pair and `out_data`=0. The next Q/I pair after release produces correct output.
- Build with `DOPPLER_MIXER_TWOS_OUT_EN` and rerun the first scenario → `out_data`=0x0800_0000.

Source files
------------

// File: rtl/doppler_iq_mixer.sv
// Pairs an interleaved offset-binary Q/I stream and outputs I*cos - Q*sin, 3-cycle latency, no backpressure.
// Optional `DOPPLER_MIXER_TWOS_OUT_EN selects a two's-complement output instead of offset binary.
module doppler_iq_mixer #(
  parameter int DATA_W  = 16,
  parameter int TRIG_W  = 17,
  parameter int OUT_W   = 32,
  parameter bit Q_FIRST = 1'b1
) (
  input  logic                     M100CLK,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  input  logic signed [TRIG_W-1:0] cos_in,
  input  logic signed [TRIG_W-1:0] sin_in,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     pair_err
);

  localparam int PW = DATA_W + TRIG_W;
  localparam int DW = PW + 1;
  localparam int SH = DW - OUT_W;

  typedef enum logic {WAIT_FIRST, WAIT_SECOND} state_t;

  state_t state_q, state_d;
  logic   cap_first, cap_second, resync;

  logic [DATA_W-1:0]        first_q, second_q;
  logic signed [TRIG_W-1:0] cos0_q, sin0_q, cos1_q, sin1_q;
  logic signed [DATA_W-1:0] i1_q, q1_q;
  logic signed [PW-1:0]     pi_q, pq_q;
  logic                     v0_q, v1_q, v2_q, out_valid_q, pair_err_q;
  logic [OUT_W-1:0]         out_data_q, out_data_d;

  logic [DATA_W-1:0]        q_raw, i_raw;
  logic signed [DW-1:0]     diff;

  always_comb begin
    state_d    = state_q;
    cap_first  = 1'b0;
    cap_second = 1'b0;
    resync     = 1'b0;
    if (in_valid) begin
      case (state_q)
        WAIT_FIRST: begin
          cap_first = 1'b1;
          state_d   = WAIT_SECOND;
        end
        default: begin
          if (in_sof) begin
            resync    = 1'b1;
            cap_first = 1'b1;
          end else begin
            cap_second = 1'b1;
            state_d    = WAIT_FIRST;
          end
        end
      endcase
    end
  end

  assign q_raw = Q_FIRST ? first_q  : second_q;
  assign i_raw = Q_FIRST ? second_q : first_q;

  // Sign-extend both products by one bit so the difference cannot overflow.
  assign diff = {pi_q[PW-1], pi_q} - {pq_q[PW-1], pq_q};

  // Dropping the SH low bits of diff is a flooring arithmetic right shift.
`ifdef DOPPLER_MIXER_TWOS_OUT_EN
  assign out_data_d = diff[DW-1:SH];
`else
  assign out_data_d = {~diff[DW-1], diff[DW-2:SH]};
`endif

  generate
    if (SH > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^diff[SH-1:0];
    end
  endgenerate

  always_ff @(posedge M100CLK) begin
    if (!reset_n) begin
      state_q     <= WAIT_FIRST;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      pair_err_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      v0_q        <= cap_second;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      pair_err_q  <= resync;
      if (v2_q) out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge M100CLK) begin
    if (cap_first) first_q <= in_data;
    if (cap_second) begin
      second_q <= in_data;
      cos0_q   <= cos_in;
      sin0_q   <= sin_in;
    end
    if (v0_q) begin
      i1_q   <= $signed({~i_raw[DATA_W-1], i_raw[DATA_W-2:0]});
      q1_q   <= $signed({~q_raw[DATA_W-1], q_raw[DATA_W-2:0]});
      cos1_q <= cos0_q;
      sin1_q <= sin0_q;
    end
    if (v1_q) begin
      pi_q <= PW'(i1_q) * PW'(cos1_q);
      pq_q <= PW'(q1_q) * PW'(sin1_q);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pair_err  = pair_err_q;

endmodule

// File: tb/tb_doppler_iq_mixer.sv
// Directed bench for doppler_iq_mixer: pairing, resync, gaps, reset mid-flight, output format.
module tb_doppler_iq_mixer;

  logic               M100CLK = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic [15:0]        in_data;
  logic               in_sof;
  logic signed [16:0] cos_in, sin_in;
  logic               out_valid;
  logic [31:0]        out_data;
  logic               pair_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int t_acc;

`ifdef DOPPLER_MIXER_TWOS_OUT_EN
  localparam logic [31:0] OFS = 32'h0000_0000;
`else
  localparam logic [31:0] OFS = 32'h8000_0000;
`endif

  doppler_iq_mixer dut (
    .M100CLK  (M100CLK),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .cos_in   (cos_in),
    .sin_in   (sin_in),
    .out_valid(out_valid),
    .out_data (out_data),
    .pair_err (pair_err)
  );

  always #5 M100CLK = ~M100CLK;
  always @(posedge M100CLK) cyc <= cyc + 1;
  always @(negedge M100CLK) begin
    if (out_valid) vcnt <= vcnt + 1;
    if (pair_err)  ecnt <= ecnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; presents one sample for one edge, then idles the bus.
  task automatic drive(input logic [15:0] d, input logic sof,
                       input logic signed [16:0] c, input logic signed [16:0] s);
    in_valid = 1'b1; in_data = d; in_sof = sof; cos_in = c; sin_in = s;
    @(posedge M100CLK); #1;
    t_acc = cyc;
    in_valid = 1'b0; in_sof = 1'b0; cos_in = '0; sin_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge M100CLK); #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp);
    int lat;
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge M100CLK); #1;
      if (out_valid) begin
        seen = 1'b1;
        lat = cyc - t_acc;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_data"}, out_data, exp);
    @(posedge M100CLK); #1;
    check({tag, "_strobe1"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, out_data, exp);
  endtask

  initial begin
    int v0, e0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    cos_in = '0; sin_in = '0;
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_pair_err", 32'(pair_err), 32'd0);
    reset_n = 1'b1;
    idle(1);

    // I=+0x4000 * cos=2^15 -> 2^29, >>2 -> 0x0800_0000
    drive(16'h8000, 1'b0, 17'sd0, 17'sd0);
    drive(16'hC000, 1'b0, 17'sd32768, 17'sd0);
    expect_out("t1", 32'h0800_0000 ^ OFS);

    // -Q*sin = -2^29 -> 0xF800_0000
    drive(16'hC000, 1'b0, 17'sd0, 17'sd0);
    drive(16'h8000, 1'b0, 17'sd0, 17'sd32768);
    expect_out("t2", 32'hF800_0000 ^ OFS);

    // Extreme corners: I=-2^15, cos=-2^16 -> 2^31 -> 0x2000_0000
    drive(16'h8000, 1'b0, 17'sd0, 17'sd0);
    drive(16'h0000, 1'b0, -17'sd65536, 17'sd0);
    expect_out("corner", 32'h2000_0000 ^ OFS);

    v0 = vcnt; e0 = ecnt;
    drive(16'h1234, 1'b0, 17'sd0, 17'sd0);
    drive(16'h8000, 1'b1, 17'sd0, 17'sd0);
    drive(16'hC000, 1'b0, 17'sd32768, 17'sd0);
    expect_out("resync", 32'h0800_0000 ^ OFS);
    idle(2);
    check("resync_err_cnt", ecnt - e0, 32'd1);
    check("resync_vld_cnt", vcnt - v0, 32'd1);

    v0 = vcnt;
    drive(16'h8000, 1'b0, 17'sd0, 17'sd0);
    idle(5);
    drive(16'hC000, 1'b0, 17'sd32768, 17'sd0);
    expect_out("gaps", 32'h0800_0000 ^ OFS);
    idle(2);
    check("gaps_vld_cnt", vcnt - v0, 32'd1);

    v0 = vcnt;
    drive(16'hC000, 1'b0, 17'sd0, 17'sd0);
    drive(16'h8000, 1'b0, 17'sd0, 17'sd32768);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(6);
    check("rst_mid_vld_cnt", vcnt - v0, 32'd0);
    check("rst_mid_out_data", out_data, 32'd0);
    check("rst_mid_pair_err", 32'(pair_err), 32'd0);

    drive(16'h8000, 1'b0, 17'sd0, 17'sd0);
    drive(16'hC000, 1'b0, 17'sd32768, 17'sd0);
    expect_out("after_rst", 32'h0800_0000 ^ OFS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
